// File: rtl/game_stats.sv
// Breakout lives / BCD score / phase tracker. Events are rising edges of level
// inputs, and each one takes effect on the clock after its edge cycle.
module game_stats #(
    parameter int INITIAL_LIVES  = 3,
    parameter int TOTAL_BLOCKS   = 208,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        frame_pulse,
    input  logic        start,
    input  logic        ball_lost,
    input  logic        block_hit,
    input  logic        stats_clear,
    output logic [2:0]  lives,
    output logic [11:0] score,
    output logic [2:0]  phase,
    output logic        respawn,
    output logic        stop_game
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAYING = 3'd1,
        RESPAWN = 3'd2,
        OVER    = 3'd3,
        WON     = 3'd4
    } phase_e;

    localparam logic [2:0] LIVES_INIT  = 3'(INITIAL_LIVES);
    localparam logic [7:0] BLOCKS_INIT = 8'(TOTAL_BLOCKS);
    localparam logic [7:0] FRAMES_INIT = 8'(RESPAWN_FRAMES);

    phase_e      phase_q, phase_d;
    logic [2:0]  lives_q, lives_d;
    logic [11:0] score_q, score_d;
    logic [7:0]  blocks_q, blocks_d;
    logic [7:0]  frames_q, frames_d;
    logic        respawn_q, respawn_d;
    logic        start_prev_q, start_prev_d;
    logic        lost_prev_q, lost_prev_d;
    logic        hit_prev_q, hit_prev_d;
    logic        start_rise, lost_rise, hit_rise, level_done;

    // Saturating three-digit BCD increment.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    assign start_rise = start & ~start_prev_q;
    assign lost_rise  = ball_lost & ~lost_prev_q;
    assign hit_rise   = block_hit & ~hit_prev_q;

    always_comb begin
        phase_d      = phase_q;
        lives_d      = lives_q;
        score_d      = score_q;
        blocks_d     = blocks_q;
        frames_d     = frames_q;
        respawn_d    = 1'b0;
        level_done   = 1'b0;
        start_prev_d = start;
        lost_prev_d  = ball_lost;
        hit_prev_d   = block_hit;
        if (stats_clear) begin
            phase_d  = IDLE;
            lives_d  = LIVES_INIT;
            score_d  = 12'h000;
            blocks_d = BLOCKS_INIT;
        end else begin
            case (phase_q)
                IDLE, OVER, WON: begin
                    if (start_rise) begin
                        phase_d  = PLAYING;
                        lives_d  = LIVES_INIT;
                        score_d  = 12'h000;
                        blocks_d = BLOCKS_INIT;
                    end
                end
                PLAYING: begin
                    if (hit_rise) begin
                        score_d  = bcd_inc(score_q);
                        blocks_d = blocks_q - 8'd1;
                        if (blocks_q == 8'd1) begin
                            phase_d    = WON;
                            level_done = 1'b1;
                        end
                    end
                    // Clearing the level on the same cycle outranks losing the ball.
                    if (lost_rise && !level_done) begin
                        if (lives_q <= 3'd1) begin
                            lives_d = 3'd0;
                            phase_d = OVER;
                        end else begin
                            lives_d  = lives_q - 3'd1;
                            phase_d  = RESPAWN;
                            frames_d = FRAMES_INIT;
                        end
                    end
                end
                RESPAWN: begin
                    if (frames_q == 8'd0) begin
                        if (!ball_lost) begin
                            phase_d   = PLAYING;
                            respawn_d = 1'b1;
                        end
                    end else if (frame_pulse) begin
                        frames_d = frames_q - 8'd1;
                    end
                end
                default: phase_d = IDLE;
            endcase
        end
    end

    // Edge history resets high so a level already asserted at release is not an event.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            phase_q      <= IDLE;
            lives_q      <= LIVES_INIT;
            score_q      <= 12'h000;
            blocks_q     <= BLOCKS_INIT;
            frames_q     <= 8'd0;
            respawn_q    <= 1'b0;
            start_prev_q <= 1'b1;
            lost_prev_q  <= 1'b1;
            hit_prev_q   <= 1'b1;
        end else begin
            phase_q      <= phase_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            blocks_q     <= blocks_d;
            frames_q     <= frames_d;
            respawn_q    <= respawn_d;
            start_prev_q <= start_prev_d;
            lost_prev_q  <= lost_prev_d;
            hit_prev_q   <= hit_prev_d;
        end
    end

    assign lives     = lives_q;
    assign score     = score_q;
    assign phase     = phase_q;
    assign respawn   = respawn_q;
    assign stop_game = (phase_q != PLAYING);

endmodule

// File: tb/tb_game_stats.sv
// Bench for game_stats: two instances (208-block and 2-block levels) share the
// stimulus; an integer-level model of the game rules is checked every cycle.
module tb_game_stats;
    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        frame_pulse = 1'b0, start = 1'b1, ball_lost = 1'b0;
    logic        block_hit = 1'b0, stats_clear = 1'b0;
    logic [2:0]  a_lives, b_lives, a_phase, b_phase;
    logic [11:0] a_score, b_score;
    logic        a_respawn, b_respawn, a_stop, b_stop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    game_stats #(.INITIAL_LIVES(3), .TOTAL_BLOCKS(208), .RESPAWN_FRAMES(60)) dut_a (
        .clk(clk), .nRst(nRst), .frame_pulse(frame_pulse), .start(start),
        .ball_lost(ball_lost), .block_hit(block_hit), .stats_clear(stats_clear),
        .lives(a_lives), .score(a_score), .phase(a_phase), .respawn(a_respawn),
        .stop_game(a_stop));

    game_stats #(.INITIAL_LIVES(3), .TOTAL_BLOCKS(2), .RESPAWN_FRAMES(60)) dut_b (
        .clk(clk), .nRst(nRst), .frame_pulse(frame_pulse), .start(start),
        .ball_lost(ball_lost), .block_hit(block_hit), .stats_clear(stats_clear),
        .lives(b_lives), .score(b_score), .phase(b_phase), .respawn(b_respawn),
        .stop_game(b_stop));

    // ---------------- behavioural model ----------------
    typedef struct {
        int phase, lives, score, blocks, cnt;
        bit rsp, pst, pbl, pbh;
    } mst_t;

    mst_t m [2];
    int   total [2] = '{208, 2};

    function automatic mst_t mreset(int tot);
        mst_t s;
        s.phase = 0; s.lives = 3; s.score = 0; s.blocks = tot; s.cnt = 0;
        s.rsp = 0; s.pst = 1; s.pbl = 1; s.pbh = 1;
        return s;
    endfunction

    function automatic mst_t mstep(mst_t s, int tot, bit st, bit bl, bit bh, bit fp, bit clr);
        mst_t n;
        bit ev_st, ev_bl, ev_bh, won;
        ev_st = st && !s.pst;
        ev_bl = bl && !s.pbl;
        ev_bh = bh && !s.pbh;
        n = s;
        n.pst = st; n.pbl = bl; n.pbh = bh; n.rsp = 0;
        won = 0;
        if (clr) begin
            n.phase = 0; n.lives = 3; n.score = 0; n.blocks = tot;
        end else if (s.phase == 0 || s.phase == 3 || s.phase == 4) begin
            if (ev_st) begin
                n.phase = 1; n.lives = 3; n.score = 0; n.blocks = tot;
            end
        end else if (s.phase == 1) begin
            if (ev_bh) begin
                n.score  = (s.score >= 999) ? 999 : s.score + 1;
                n.blocks = s.blocks - 1;
                if (n.blocks == 0) begin n.phase = 4; won = 1; end
            end
            if (ev_bl && !won) begin
                n.lives = (s.lives > 0) ? s.lives - 1 : 0;
                if (n.lives == 0) n.phase = 3;
                else begin n.phase = 2; n.cnt = 60; end
            end
        end else if (s.phase == 2) begin
            if (s.cnt == 0 && !bl) begin n.phase = 1; n.rsp = 1; end
            else if (s.cnt > 0 && fp) n.cnt = s.cnt - 1;
        end
        return n;
    endfunction

    function automatic logic [19:0] mexp(mst_t s);
        logic [11:0] bcd;
        bcd = {4'(s.score / 100), 4'((s.score / 10) % 10), 4'(s.score % 10)};
        return {3'(s.lives), bcd, 3'(s.phase), s.rsp, (s.phase != 1)};
    endfunction

    initial begin
        m[0] = mreset(total[0]);
        m[1] = mreset(total[1]);
        forever begin
            @(posedge clk or negedge nRst);
            for (int i = 0; i < 2; i++) begin
                if (!nRst) m[i] = mreset(total[i]);
                else m[i] = mstep(m[i], total[i], start, ball_lost, block_hit,
                                  frame_pulse, stats_clear);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [19:0] ga, gb, ea, eb;
        forever begin
            @(negedge clk);
            if (nRst) begin
                ga = {a_lives, a_score, a_phase, a_respawn, a_stop};
                gb = {b_lives, b_score, b_phase, b_respawn, b_stop};
                ea = mexp(m[0]);
                eb = mexp(m[1]);
                n_tests += 2;
                if (ga !== ea) begin
                    n_fail++;
                    $display("FAIL model_a t=%0t got %h exp %h (lives,score,phase,rsp,stop)", $time, ga, ea);
                end
                if (gb !== eb) begin
                    n_fail++;
                    $display("FAIL model_b t=%0t got %h exp %h (lives,score,phase,rsp,stop)", $time, gb, eb);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic respawn_wait();
        for (int k = 0; k < 60; k++) begin
            frame_pulse = 1'b1; step();
            frame_pulse = 1'b0; step();
        end
    endtask

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("rst_phase", 16'(a_phase), 16'd0);
        chk("rst_lives", 16'(a_lives), 16'd3);
        chk("rst_score", 16'(a_score), 16'h000);
        chk("rst_stop",  16'(a_stop),  16'd1);
        chk("rst_rsp",   16'(a_respawn), 16'd0);

        step(); nRst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("start_held_idle", 16'(a_phase), 16'd0);

        step(); start = 1'b0; step(); start = 1'b1; step();
        @(negedge clk);
        chk("start_phase", 16'(a_phase), 16'd1);
        chk("start_stop",  16'(a_stop),  16'd0);
        chk("start_lives", 16'(a_lives), 16'd3);
        chk("start_score", 16'(a_score), 16'h000);
        step(); start = 1'b0;

        for (int k = 0; k < 12; k++) begin
            block_hit = 1'b1; step();
            block_hit = 1'b0; step();
        end
        @(negedge clk);
        chk("score_12", 16'(a_score), 16'h012);

        // Preload 999 by force; the hit while forced and one after must both saturate.
        step();
        force dut_a.score_q = 12'h999;
        m[0].score = 999;
        block_hit = 1'b1; step();
        release dut_a.score_q;
        block_hit = 1'b0; step();
        block_hit = 1'b1; step();
        block_hit = 1'b0; step();
        @(negedge clk);
        chk("score_sat", 16'(a_score), 16'h999);

        step(); ball_lost = 1'b1; step();
        @(negedge clk);
        chk("lost_lives", 16'(a_lives), 16'd2);
        chk("lost_phase", 16'(a_phase), 16'd2);
        step(); ball_lost = 1'b0; step();
        for (int k = 0; k < 59; k++) begin
            frame_pulse = 1'b1; step();
            frame_pulse = 1'b0; step();
        end
        frame_pulse = 1'b1; step();
        frame_pulse = 1'b0;
        @(negedge clk);
        chk("rsp_hold_phase", 16'(a_phase), 16'd2);
        step();
        @(negedge clk);
        chk("rsp_phase", 16'(a_phase), 16'd1);
        chk("rsp_pulse", 16'(a_respawn), 16'd1);
        step();
        @(negedge clk);
        chk("rsp_pulse_end", 16'(a_respawn), 16'd0);

        step(); ball_lost = 1'b1; step(); ball_lost = 1'b0; step();
        respawn_wait(); step(); step();
        ball_lost = 1'b1; step();
        @(negedge clk);
        chk("over_lives", 16'(a_lives), 16'd0);
        chk("over_phase", 16'(a_phase), 16'd3);
        chk("over_stop",  16'(a_stop),  16'd1);
        step(); ball_lost = 1'b0; step();
        start = 1'b1; step();
        @(negedge clk);
        chk("restart_phase", 16'(a_phase), 16'd1);
        chk("restart_lives", 16'(a_lives), 16'd3);
        chk("restart_score", 16'(a_score), 16'h000);
        step(); start = 1'b0; step();

        block_hit = 1'b1; step(); block_hit = 1'b0; step();
        block_hit = 1'b1; ball_lost = 1'b1; step();
        @(negedge clk);
        chk("won_phase", 16'(b_phase), 16'd4);
        chk("won_lives", 16'(b_lives), 16'd3);
        chk("won_score", 16'(b_score), 16'h002);
        step(); block_hit = 1'b0; ball_lost = 1'b0; step();

        stats_clear = 1'b1; step(); stats_clear = 1'b0; step();
        start = 1'b1; step(); start = 1'b0; step();
        block_hit = 1'b1; step(); block_hit = 1'b0; step();
        @(negedge clk);
        chk("pre_clr_score", 16'(a_score), 16'h001);
        step();
        stats_clear = 1'b1; block_hit = 1'b1; step();
        @(negedge clk);
        chk("clr_phase", 16'(a_phase), 16'd0);
        chk("clr_score", 16'(a_score), 16'h000);
        chk("clr_lives", 16'(a_lives), 16'd3);
        step(); stats_clear = 1'b0; block_hit = 1'b0; step();

        start = 1'b1; step(); start = 1'b0; step();
        block_hit = 1'b1; step(); block_hit = 1'b0; step();
        #2 nRst = 1'b0;
        #1;
        chk("async_rst_phase", 16'(a_phase), 16'd0);
        chk("async_rst_score", 16'(a_score), 16'h000);
        step(); step(); nRst = 1'b1; step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
